// File: rtl/fir_inverse.sv
// All-pole inverse of the monic 4-tap FIR: x[n] = y[n] - c1*x[n-1] - c2*x[n-2] - c3*x[n-3] mod 2^DATA_W.
// Optional macro COEF_LOAD_EN adds runtime coefficient loading (coef_load/coef_data/coef_valid and a LOAD state).
module fir_inverse #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              hist_clr
`ifdef COEF_LOAD_EN
    ,
    input  logic              coef_load,
    input  logic [DATA_W-1:0] coef_data,
    input  logic              coef_valid
`endif
);

    logic [DATA_W-1:0] w_coef [3];
    logic [DATA_W-1:0] r_hist [3];
    logic [DATA_W-1:0] w_term [3];
    logic [DATA_W-1:0] w_sample;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              w_run;
    logic              w_load_done;
    logic              w_accept;
    logic              w_hist_zero;

`ifdef COEF_LOAD_EN
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_beat;
    logic [1:0]        w_beat_next;
    logic              w_coef_wr;
    logic [DATA_W-1:0] r_coef [3];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_beat  <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_beat  <= w_beat_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        w_coef_wr    = 1'b0;
        w_load_done  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (coef_load) begin
                    w_state_next = ST_LOAD;
                    w_beat_next  = 2'd0;
                end
            end
            ST_LOAD: begin
                if (coef_load) begin
                    w_beat_next = 2'd0;
                end else if (coef_valid) begin
                    w_coef_wr = 1'b1;
                    if (r_beat == 2'd2) begin
                        w_state_next = ST_RUN;
                        w_beat_next  = 2'd0;
                        w_load_done  = 1'b1;
                    end else begin
                        w_beat_next = r_beat + 2'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_RUN;
                w_beat_next  = 2'd0;
            end
        endcase
    end

    // A load pulse blocks acceptance already in the cycle it arrives.
    assign w_run = (r_state == ST_RUN) && !coef_load;

    for (genvar gi = 0; gi < 3; gi++) begin : g_coef
        always_ff @(posedge clk) begin
            if (reset) begin
                r_coef[gi] <= DATA_W'(1);
            end else if (w_coef_wr && (r_beat == 2'(gi))) begin
                r_coef[gi] <= coef_data;
            end
        end
        assign w_coef[gi] = r_coef[gi];
    end
`else
    assign w_run       = 1'b1;
    assign w_load_done = 1'b0;
    for (genvar gi = 0; gi < 3; gi++) begin : g_coef
        assign w_coef[gi] = DATA_W'(1);
    end
`endif

    // A DATA_W-wide product is exactly the low half of the full product.
    for (genvar gi = 0; gi < 3; gi++) begin : g_term
        assign w_term[gi] = w_coef[gi] * r_hist[gi];
    end

    assign w_sample    = in_data - w_term[0] - w_term[1] - w_term[2];
    assign in_ready    = !reset && w_run && !hist_clr && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_hist_zero = hist_clr || w_load_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist[0] <= '0;
            r_hist[1] <= '0;
            r_hist[2] <= '0;
        end else if (w_hist_zero) begin
            r_hist[0] <= '0;
            r_hist[1] <= '0;
            r_hist[2] <= '0;
        end else if (w_accept) begin
            r_hist[0] <= w_sample;
            r_hist[1] <= r_hist[0];
            r_hist[2] <= r_hist[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_data  <= w_sample;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_fir_inverse.sv
// Randomized and directed bench for fir_inverse against a sample-history reference model.
// Define COEF_LOAD_EN to also exercise the coefficient-load path.
module tb_fir_inverse;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       hist_clr = 1'b0;
    logic       coef_load = 1'b0;
    logic [7:0] coef_data = '0;
    logic       coef_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: last three reconstructed samples, current coefficients, output slot.
    int m_hist [3];
    int m_coef [3];
    bit m_ov;
    int m_od;
    bit m_load;
    int m_beat;

    always #5 clk = ~clk;

    fir_inverse #(.DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hist_clr  (hist_clr)
`ifdef COEF_LOAD_EN
        ,
        .coef_load (coef_load),
        .coef_data (coef_data),
        .coef_valid(coef_valid)
`endif
    );

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_hist[i] = 0;
            m_coef[i] = 1;
        end
        m_ov = 0; m_od = 0; m_load = 0; m_beat = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; hist_clr = 1'b0;
        coef_load = 1'b0; coef_valid = 1'b0;
        @(negedge clk);
        check_value("ready_in_reset", int'(in_ready), 0);
        model_reset();
        @(posedge clk); #1;
        check_value("reset_out_valid", int'(out_valid), 0);
        check_value("reset_out_data", int'(out_data), 0);
        reset = 1'b0;
        $display("reset: out_valid=%0d out_data=%0d", out_valid, out_data);
    endtask

    // One clock cycle: drive, check in_ready, advance model, check outputs after the edge.
    task automatic cycle(input bit v, input int d, input bit rdy, input bit clr,
                         input bit cl, input int cd, input bit cv);
        bit exp_ready;
        bit blocked;
        int x;
        in_valid = v; in_data = 8'(d); out_ready = rdy; hist_clr = clr;
        coef_load = cl; coef_data = 8'(cd); coef_valid = cv;
        blocked = 0;
`ifdef COEF_LOAD_EN
        blocked = m_load || cl;
`endif
        @(negedge clk);
        exp_ready = !blocked && !clr && (!m_ov || rdy);
        check_value("in_ready", int'(in_ready), int'(exp_ready));
        if (v && exp_ready) begin
            x = (d - m_coef[0] * m_hist[0] - m_coef[1] * m_hist[1] - m_coef[2] * m_hist[2]) & 255;
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = x;
            m_ov = 1;
            m_od = x;
        end else if (rdy) begin
            m_ov = 0;
        end
        if (clr) begin
            for (int i = 0; i < 3; i++) m_hist[i] = 0;
        end
`ifdef COEF_LOAD_EN
        if (cl) begin
            m_load = 1;
            m_beat = 0;
        end else if (m_load && cv) begin
            m_coef[m_beat] = cd;
            m_beat++;
            if (m_beat == 3) begin
                m_load = 0;
                m_beat = 0;
                for (int i = 0; i < 3; i++) m_hist[i] = 0;
            end
        end
`endif
        @(posedge clk); #1;
        check_value("out_valid", int'(out_valid), int'(m_ov));
        if (m_ov) check_value("out_data", int'(out_data), m_od);
        $display("cyc v=%0d y=%0d rdy=%0d clr=%0d ld=%0d cv=%0d cd=%0d -> in_ready=%0d out_valid=%0d out_data=%0d",
                 v, d, rdy, clr, cl, cv, cd, exp_ready, out_valid, out_data);
    endtask

    task automatic feed(input int d, input int exp_x, input string tag);
        cycle(1, d, 1, 0, 0, 0, 0);
        check_value(tag, int'(out_data), exp_x);
    endtask

    task automatic impulse();
        feed(5, 5, "impulse0");
        feed(5, 0, "impulse1");
        feed(5, 0, "impulse2");
        feed(5, 0, "impulse3");
        feed(0, 0, "impulse4");
        feed(0, 0, "impulse5");
    endtask

    initial begin
        model_reset();
        do_reset();

        impulse();

        do_reset();
        feed(200, 200, "wrap0");
        feed(44, 100, "wrap1");

        // Backpressure: hold a pending output, then drain and accept together.
        do_reset();
        cycle(1, 17, 0, 0, 0, 0, 0);
        cycle(1, 30, 0, 0, 0, 0, 0);
        check_value("bp_hold_data", int'(out_data), 17);
        cycle(1, 30, 1, 0, 0, 0, 0);
        check_value("bp_drain_accept", int'(out_data), 13);
        check_value("bp_valid", int'(out_valid), 1);
        cycle(0, 0, 1, 0, 0, 0, 0);

        // History clear between two samples.
        do_reset();
        feed(5, 5, "hclr0");
        cycle(1, 9, 1, 1, 0, 0, 0);
        feed(5, 5, "hclr1");

`ifdef COEF_LOAD_EN
        do_reset();
        cycle(0, 0, 1, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0, 2, 1);
        cycle(1, 1, 1, 0, 0, 0, 1);
        cycle(1, 1, 1, 0, 0, 0, 1);
        feed(3, 3, "coef0");
        feed(6, 0, "coef1");

        // Reset in the middle of a load restores unit coefficients.
        cycle(0, 0, 1, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0, 9, 1);
        do_reset();
        impulse();
`endif

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            bit cl;
            bit cv;
            cl = 0;
            cv = 0;
`ifdef COEF_LOAD_EN
            cl = ($urandom_range(0, 31) == 0);
            cv = $urandom_range(0, 1) == 1;
`endif
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  cl, int'($urandom_range(0, 255)), cv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
